// File: rtl/trafficlight_ctrl.sv
// -----------------------------------------------------------------------------
// trafficlight_ctrl
//   Two-road (NS / EW) intersection controller with configurable phase
//   durations and a latched pedestrian request. A pending request shortens the
//   current green to MIN_GREEN_T and is served as an all-red WALK phase after
//   the next clearance.
//
//   Optional build macro: TL_FLASH_EN
//     When defined, adds input flash_req and parameter FLASH_T. While
//     flash_req is high, both roads flash yellow. Dropping flash_req goes to
//     all-red, and the next green is NS.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   pdst      in   pedestrian button (level or pulse)
//   flash_req in   flash override request (TL_FLASH_EN only)
//   light_ns  out  NS lamps one-hot: 100 red, 010 yellow, 001 green
//   light_ew  out  EW lamps, same encoding
//   walk      out  pedestrian walk signal
//   ped_pend  out  latched pedestrian request indicator
// -----------------------------------------------------------------------------
module trafficlight_ctrl #(
  parameter int GREEN_T     = 20,
  parameter int MIN_GREEN_T = 5,
  parameter int YELLOW_T    = 4,
  parameter int ALLRED_T    = 2,
  parameter int WALK_T      = 10,
  parameter int CNT_W       = 8
`ifdef TL_FLASH_EN
  , parameter int FLASH_T   = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pdst,
`ifdef TL_FLASH_EN
  input  logic       flash_req,
`endif
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk,
  output logic       ped_pend
);

  typedef enum logic [2:0] {
    PH_GREEN  = 3'd0,
    PH_YELLOW = 3'd1,
    PH_ALLRED = 3'd2,
    PH_WALK   = 3'd3
`ifdef TL_FLASH_EN
    , PH_FLASH = 3'd4
`endif
  } phase_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Terminal counts: a phase of duration D ends when the counter reaches D-1.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam int               CNT_MAX     = (1 << CNT_W) - 1;

`ifdef TL_FLASH_EN
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_T - 1);
  localparam bit FLASH_OK = (FLASH_T >= 1) && ((FLASH_T - 1) <= CNT_MAX);
`else
  localparam bit FLASH_OK = 1'b1;
`endif

  localparam bit CFG_OK = (GREEN_T >= 1) && (YELLOW_T >= 1) && (ALLRED_T >= 1) &&
                          (WALK_T >= 1) && (MIN_GREEN_T >= 1) &&
                          (MIN_GREEN_T <= GREEN_T) &&
                          ((GREEN_T - 1) <= CNT_MAX) && ((YELLOW_T - 1) <= CNT_MAX) &&
                          ((ALLRED_T - 1) <= CNT_MAX) && ((WALK_T - 1) <= CNT_MAX) &&
                          FLASH_OK;

  phase_t           r_phase;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ped;
  logic             r_flash_on;

  phase_t           w_phase_nxt;
  logic             w_dir_nxt;
  logic             w_cnt_clr;
  logic             w_ped_nxt;
  logic             w_ped_set;
  logic             w_flash_on_nxt;

  // Parameter sanity check, evaluated once at start of simulation.
  always_comb begin
    if (!CFG_OK) begin
      $error("trafficlight_ctrl: duration parameters out of range for CNT_W=%0d", CNT_W);
    end else begin
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase    <= PH_GREEN;
      r_dir      <= 1'b0;
      r_cnt      <= '0;
      r_ped      <= 1'b0;
      r_flash_on <= 1'b0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_dir      <= w_dir_nxt;
      r_cnt      <= w_cnt_clr ? '0 : (r_cnt + CNT_ONE);
      r_ped      <= w_ped_nxt;
      r_flash_on <= w_flash_on_nxt;
    end
  end

  // Next-state logic: phase sequencing, direction, counter clear, request latch.
  always_comb begin
    w_phase_nxt    = r_phase;
    w_dir_nxt      = r_dir;
    w_cnt_clr      = 1'b0;
    w_ped_set      = pdst && (r_phase != PH_WALK);
    w_ped_nxt      = r_ped | w_ped_set;
    w_flash_on_nxt = r_flash_on;

    case (r_phase)
      PH_GREEN: begin
        if ((r_cnt == GREEN_LAST) || (r_ped && (r_cnt >= MIN_LAST))) begin
          w_phase_nxt = PH_YELLOW;
          w_cnt_clr   = 1'b1;
        end else begin
        end
      end
      PH_YELLOW: begin
        if (r_cnt == YELLOW_LAST) begin
          w_phase_nxt = PH_ALLRED;
          w_dir_nxt   = ~r_dir;
          w_cnt_clr   = 1'b1;
        end else begin
        end
      end
      PH_ALLRED: begin
        if (r_cnt == ALLRED_LAST) begin
          w_cnt_clr = 1'b1;
          if (r_ped) begin
            // Entering WALK consumes the request; a same-cycle press is dropped.
            w_phase_nxt = PH_WALK;
            w_ped_nxt   = 1'b0;
          end else begin
            w_phase_nxt = PH_GREEN;
          end
        end else begin
        end
      end
      PH_WALK: begin
        // dir already toggled at the clearance, so the next green is the other road.
        if (r_cnt == WALK_LAST) begin
          w_phase_nxt = PH_GREEN;
          w_cnt_clr   = 1'b1;
        end else begin
        end
      end
`ifdef TL_FLASH_EN
      PH_FLASH: begin
        if (!flash_req) begin
          // dir=0 so the all-red exit hands green to NS.
          w_phase_nxt    = PH_ALLRED;
          w_dir_nxt      = 1'b0;
          w_cnt_clr      = 1'b1;
          w_flash_on_nxt = 1'b0;
        end else if (r_cnt == FLASH_LAST) begin
          w_cnt_clr      = 1'b1;
          w_flash_on_nxt = ~r_flash_on;
        end else begin
        end
      end
`endif
      default: begin
        w_phase_nxt = PH_GREEN;
        w_dir_nxt   = 1'b0;
        w_cnt_clr   = 1'b1;
        w_ped_nxt   = 1'b0;
      end
    endcase

`ifdef TL_FLASH_EN
    // Flash overrides any phase; a request is kept rather than consumed.
    if (flash_req && (r_phase != PH_FLASH)) begin
      w_phase_nxt    = PH_FLASH;
      w_dir_nxt      = r_dir;
      w_cnt_clr      = 1'b1;
      w_flash_on_nxt = 1'b1;
      w_ped_nxt      = r_ped | w_ped_set;
    end else begin
    end
`endif
  end

  // Moore output decode from registered state.
  always_comb begin
    light_ns = LAMP_RED;
    light_ew = LAMP_RED;
    walk     = 1'b0;
    case (r_phase)
      PH_GREEN: begin
        if (r_dir) begin
          light_ew = LAMP_GRN;
        end else begin
          light_ns = LAMP_GRN;
        end
      end
      PH_YELLOW: begin
        if (r_dir) begin
          light_ew = LAMP_YEL;
        end else begin
          light_ns = LAMP_YEL;
        end
      end
      PH_ALLRED: begin
        light_ns = LAMP_RED;
      end
      PH_WALK: begin
        walk = 1'b1;
      end
`ifdef TL_FLASH_EN
      PH_FLASH: begin
        light_ns = r_flash_on ? LAMP_YEL : LAMP_OFF;
        light_ew = r_flash_on ? LAMP_YEL : LAMP_OFF;
      end
`endif
      default: begin
        walk = 1'b0;
      end
    endcase
  end

  assign ped_pend = r_ped;

endmodule
